identify_sequencer: RTL and testbench

Front-end controller that feeds the `Identify` decode stage. It buffers 32-bit instruction words from fetch and assembles prefixed instructions (prefix + suffix) into one 64-bit slot. It presents one instruction at a time to `Identify` under a valid/ready handshake and discards all in-flight state on a branch redirect (flush).

---
 rtl/identify_sequencer_pkg.sv | 16 +
 rtl/identify_sequencer_if.sv | 30 +++
 rtl/identify_sequencer_word_fifo.sv | 53 +++++
 rtl/identify_sequencer.sv | 100 ++++++++++
 tb/tb_identify_sequencer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/identify_sequencer_pkg.sv
// Shared types and helpers for the Identify front-end sequencer.
package identify_pkg;

  localparam logic [5:0] PRIMARY_OPCODE_PREFIX = 6'b100000;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_PREFIX,
    S_FULL
  } seq_state_t;

  function automatic logic is_prefix(input logic [31:0] word);
    return word[5:0] == PRIMARY_OPCODE_PREFIX;
  endfunction

endpackage

// File: rtl/identify_sequencer_if.sv
// Fetch-side and Identify-side handshake bundle of the sequencer.
interface identify_sequencer_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          i_word_valid;
  logic [31:0]   i_word;
  logic          o_word_ready;
  logic          o_instr_valid;
  logic [63:0]   o_instr;
  logic          o_instr_prefixed;
  logic          i_instr_ready;
  logic          o_err_prefix;
  logic [CW-1:0] o_fifo_count;

  // Sequencer side
  modport master (
    input  i_word_valid, i_word, i_instr_ready,
    output o_word_ready, o_instr_valid, o_instr, o_instr_prefixed,
           o_err_prefix, o_fifo_count
  );

  // Fetch / Identify side
  modport slave (
    output i_word_valid, i_word, i_instr_ready,
    input  o_word_ready, o_instr_valid, o_instr, o_instr_prefixed,
           o_err_prefix, o_fifo_count
  );
endinterface

// File: rtl/identify_sequencer_word_fifo.sv
// Instruction word FIFO; head is registered state, so there is no bypass.
module word_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic [31:0]              i_data,
  input  logic                     i_pop,
  output logic [31:0]              o_head,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (i_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (i_push && !i_pop)      count_d = count_q + CW'(1);
    else if (!i_push && i_pop) count_d = count_q - CW'(1);
  end

  // Pointer/occupancy registers; clear discards contents on redirect
  always_ff @(posedge i_clk) begin
    if (!i_rst || i_clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write
  always_ff @(posedge i_clk) begin
    if (i_push) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;
endmodule

// File: rtl/identify_sequencer.sv
// Buffers fetch words and assembles prefix+suffix pairs into one 64-bit slot.
module identify_sequencer
  import identify_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  identify_sequencer_if.master bus
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  seq_state_t    state_q, state_d;
  logic [63:0]   instr_q, instr_d;
  logic          prefixed_q, prefixed_d;
  logic          err_q, err_d;
  logic          push, pop, take_head, fifo_nonempty;
  logic [31:0]   head;
  logic [CW-1:0] count;

  assign bus.o_word_ready = (count < CW'(DEPTH)) && !i_flush;
  assign push             = bus.i_word_valid && bus.o_word_ready;
  assign fifo_nonempty    = count != '0;

  word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (i_flush),
    .i_push  (push),
    .i_data  (bus.i_word),
    .i_pop   (pop),
    .o_head  (head),
    .o_count (count)
  );

  // Assembler next-state: a free slot (empty or consumed this cycle) takes the head
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    prefixed_d = prefixed_q;
    err_d      = 1'b0;
    pop        = 1'b0;
    take_head  = 1'b0;
    if (i_flush) begin
      state_d = S_EMPTY;
    end else begin
      unique case (state_q)
        S_EMPTY: take_head = 1'b1;
        S_FULL: begin
          if (bus.i_instr_ready) begin
            take_head = 1'b1;
            state_d   = S_EMPTY;
          end
        end
        S_PREFIX: begin
          if (fifo_nonempty) begin
            pop = 1'b1;
            if (is_prefix(head)) begin
              instr_d[31:0] = head;
              err_d         = 1'b1;
            end else begin
              instr_d[63:32] = head;
              prefixed_d     = 1'b1;
              state_d        = S_FULL;
            end
          end
        end
        default: state_d = S_EMPTY;
      endcase
      if (take_head && fifo_nonempty) begin
        pop        = 1'b1;
        instr_d    = {32'b0, head};
        prefixed_d = 1'b0;
        state_d    = is_prefix(head) ? S_PREFIX : S_FULL;
      end
    end
  end

  // State and output slot registers
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= S_EMPTY;
      instr_q    <= '0;
      prefixed_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      prefixed_q <= prefixed_d;
      err_q      <= err_d;
    end
  end

  assign bus.o_instr_valid    = state_q == S_FULL;
  assign bus.o_instr          = instr_q;
  assign bus.o_instr_prefixed = prefixed_q;
  assign bus.o_err_prefix     = err_q;
  assign bus.o_fifo_count     = count;
endmodule

// File: tb/tb_identify_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue model.
module tb_identify_sequencer;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   failures = 0;

  identify_sequencer_if #(.DEPTH(DEPTH)) bus ();

  identify_sequencer #(.DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (flush),
    .bus     (bus)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a word queue, an output slot and a held prefix
  logic [31:0] mq[$];
  bit          m_live = 0;
  bit          m_slot_v = 0;
  logic [63:0] m_instr = '0;
  bit          m_pref = 0;
  bit          m_held = 0;
  logic [31:0] m_held_w = '0;
  bit          m_err = 0;

  function automatic bit pfx(input logic [31:0] w);
    return w[5:0] == 6'h20;
  endfunction

  initial forever begin
    @(posedge clk);
    if (!rst) begin
      mq.delete(); m_slot_v = 0; m_held = 0; m_err = 0;
      m_instr = '0; m_pref = 0; m_live = 1;
    end else if (flush) begin
      mq.delete(); m_slot_v = 0; m_held = 0; m_err = 0;
    end else begin
      bit          push_ok;
      logic [31:0] w;
      logic [31:0] win;
      push_ok = bus.i_word_valid && (mq.size() < DEPTH);
      win     = bus.i_word;
      m_err   = 0;
      if (m_slot_v && bus.i_instr_ready) m_slot_v = 0;
      if (!m_slot_v && mq.size() > 0) begin
        w = mq.pop_front();
        if (m_held) begin
          if (pfx(w)) begin
            m_err = 1; m_held_w = w;
          end else begin
            m_instr = {w, m_held_w}; m_pref = 1; m_slot_v = 1; m_held = 0;
          end
        end else if (pfx(w)) begin
          m_held = 1; m_held_w = w;
        end else begin
          m_instr = {32'b0, w}; m_pref = 0; m_slot_v = 1;
        end
      end
      if (push_ok) mq.push_back(win);
    end
  end

  // Cycle-by-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (m_live) begin
      check("valid", 64'(bus.o_instr_valid), 64'(m_slot_v));
      check("count", 64'(bus.o_fifo_count), 64'(mq.size()));
      check("err_prefix", 64'(bus.o_err_prefix), 64'(m_err));
      check("word_ready", 64'(bus.o_word_ready), 64'((mq.size() < DEPTH) && !flush));
      if (m_slot_v) begin
        check("instr", bus.o_instr, m_instr);
        check("prefixed", 64'(bus.o_instr_prefixed), 64'(m_pref));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    bus.i_word_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc;
    int          n;
    bit          was;
    logic [31:0] w;

    bus.i_word_valid  = 1'b0;
    bus.i_word        = '0;
    bus.i_instr_ready = 1'b1;

    // Reset
    tick(); tick();
    rst = 1'b1;
    check("rst_valid", 64'(bus.o_instr_valid), 64'd0);
    check("rst_instr", bus.o_instr, 64'd0);
    check("rst_prefixed", 64'(bus.o_instr_prefixed), 64'd0);
    check("rst_err", 64'(bus.o_err_prefix), 64'd0);
    check("rst_count", 64'(bus.o_fifo_count), 64'd0);
    check("rst_ready", 64'(bus.o_word_ready), 64'd1);

    // Single non-prefixed word
    bus.i_word_valid = 1'b1; bus.i_word = 32'h4800_0012;
    tick();                                  // edge N
    bus.i_word_valid = 1'b0;
    check("A_N_valid", 64'(bus.o_instr_valid), 64'd0);
    tick();                                  // edge N+1
    check("A_valid", 64'(bus.o_instr_valid), 64'd1);
    check("A_instr", bus.o_instr, 64'h0000_0000_4800_0012);
    check("A_prefixed", 64'(bus.o_instr_prefixed), 64'd0);
    tick();
    check("A_one_cycle", 64'(bus.o_instr_valid), 64'd0);
    idle(2);

    // Prefix + suffix
    bus.i_word_valid = 1'b1; bus.i_word = 32'h0000_0020;
    tick();
    bus.i_word = 32'h1234_5678;
    tick();
    bus.i_word_valid = 1'b0;
    check("B_N1_valid", 64'(bus.o_instr_valid), 64'd0);
    tick();
    check("B_valid", 64'(bus.o_instr_valid), 64'd1);
    check("B_instr", bus.o_instr, 64'h1234_5678_0000_0020);
    check("B_prefixed", 64'(bus.o_instr_prefixed), 64'd1);
    tick();
    check("B_one_cycle", 64'(bus.o_instr_valid), 64'd0);
    idle(2);

    // Prefix, prefix, suffix
    bus.i_word_valid = 1'b1; bus.i_word = 32'h0000_0020;
    tick();
    bus.i_word = 32'hABCD_0020;
    tick();
    check("C_err_e1", 64'(bus.o_err_prefix), 64'd0);
    bus.i_word = 32'h1111_0001;
    tick();
    bus.i_word_valid = 1'b0;
    check("C_err_e2", 64'(bus.o_err_prefix), 64'd1);
    tick();
    check("C_err_e3", 64'(bus.o_err_prefix), 64'd0);
    check("C_valid", 64'(bus.o_instr_valid), 64'd1);
    check("C_instr", bus.o_instr, 64'h1111_0001_ABCD_0020);
    check("C_prefixed", 64'(bus.o_instr_prefixed), 64'd1);
    idle(3);

    // Backpressure with six words
    bus.i_instr_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 12 && acc < 5; c++) begin
      bus.i_word_valid = 1'b1;
      bus.i_word = 32'h0000_0100 + 32'(acc);
      was = bus.o_word_ready;
      tick();
      if (was) acc++;
    end
    check("D_accepts", 64'(acc), 64'd5);
    check("D_ready_low", 64'(bus.o_word_ready), 64'd0);
    check("D_count", 64'(bus.o_fifo_count), 64'd4);
    check("D_slot", bus.o_instr, 64'h0000_0000_0000_0100);
    bus.i_word = 32'h0000_0105;
    tick(); tick();
    check("D_count_hold", 64'(bus.o_fifo_count), 64'd4);
    bus.i_instr_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 30 && n < 6; c++) begin
      if (bus.o_instr_valid) begin
        check("D_order", bus.o_instr, 64'(32'h0000_0100 + 32'(n)));
        n++;
      end
      was = bus.i_word_valid && bus.o_word_ready;
      tick();
      if (was) bus.i_word_valid = 1'b0;
    end
    check("D_emitted", 64'(n), 64'd6);
    idle(3);

    // Flush with slot full and three words queued
    bus.i_instr_ready = 1'b0;
    bus.i_word_valid = 1'b1;
    bus.i_word = 32'h0000_0013; tick();
    bus.i_word = 32'h0000_0020; tick();
    bus.i_word = 32'h5555_0001; tick();
    bus.i_word = 32'h0000_0044; tick();
    check("E_pre_valid", 64'(bus.o_instr_valid), 64'd1);
    check("E_pre_count", 64'(bus.o_fifo_count), 64'd3);
    flush = 1'b1;
    bus.i_word = 32'h0000_0099;
    #1;
    check("E_ready_in_flush", 64'(bus.o_word_ready), 64'd0);
    tick();
    flush = 1'b0;
    bus.i_word_valid = 1'b0;
    check("E_valid", 64'(bus.o_instr_valid), 64'd0);
    check("E_count", 64'(bus.o_fifo_count), 64'd0);
    bus.i_instr_ready = 1'b1;
    tick();
    check("E_count_after", 64'(bus.o_fifo_count), 64'd0);
    check("E_valid_after", 64'(bus.o_instr_valid), 64'd0);
    idle(2);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      w = $urandom;
      if ($urandom_range(2) == 0) w[5:0] = 6'h20;
      else if (w[5:0] == 6'h20) w[0] = 1'b1;
      bus.i_word        = w;
      bus.i_word_valid  = $urandom_range(9) < 7;
      bus.i_instr_ready = $urandom_range(9) < 6;
      flush             = $urandom_range(39) == 0;
      rst               = !($urandom_range(499) == 0);
      tick();
    end
    rst = 1'b1; flush = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
